// File: rtl/dvi_timing_pkg.sv
// Shared video-mode constants and sync helper for the DVI timing generator.
// Modes are grouped as structs so a top can pick one set with a single name.
package dvi_timing_pkg;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
    bit hs_pol;
    bit vs_pol;
  } video_mode_t;

  localparam video_mode_t MODE_800X600_60  = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};
  localparam video_mode_t MODE_640X480_60  = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  localparam video_mode_t MODE_1024X768_60 = '{1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0};

  function automatic logic sync_level(input logic raw, input logic pol);
    return raw ? pol : ~pol;
  endfunction

endpackage

// File: rtl/dvi_sync_delay.sv
// Parametrised-depth shift register with clock enable and per-bit reset values.
// DEPTH = 0 is a plain wire.
module dvi_sync_delay #(
  parameter int             DEPTH = 0,
  parameter int             W     = 3,
  parameter logic [W-1:0]   INIT  = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n, ce};
    assign q = d;
  end else begin : g_shift
    logic [W-1:0] stage_q [DEPTH];
    logic [W-1:0] stage_d [DEPTH];

    always_comb begin
      stage_d[0] = d;
      for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    end

    // NOTE: every stage is reset, not just the head, so the tail shows
    // inactive sync levels on the very next edge instead of stale history.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= INIT;
      end else if (ce) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/dvi_video_timing.sv
// Video timing generator: h/v counters, registered pixel coordinates and strobes,
// and DE/HSYNC/VSYNC delayed by PIPE_DLY enabled cycles for a pipelined pixel source.
module dvi_video_timing
  import dvi_timing_pkg::*;
#(
  parameter int H_ACTIVE = MODE_800X600_60.h_active,
  parameter int H_FP     = MODE_800X600_60.h_fp,
  parameter int H_SYNC   = MODE_800X600_60.h_sync,
  parameter int H_BP     = MODE_800X600_60.h_bp,
  parameter int V_ACTIVE = MODE_800X600_60.v_active,
  parameter int V_FP     = MODE_800X600_60.v_fp,
  parameter int V_SYNC   = MODE_800X600_60.v_sync,
  parameter int V_BP     = MODE_800X600_60.v_bp,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int PIPE_DLY = 0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          pix_active,
  output logic          line_start,
  output logic          frame_start,
  output logic          vga_de,
  output logic          vga_hs,
  output logic          vga_vs
);

  localparam logic [XW-1:0] H_LAST  = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT   = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_LAST = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] V_LAST  = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT   = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_LAST = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [2:0]    SYNC_IDLE = {~VS_POL, ~HS_POL, 1'b0};

  logic [XW-1:0] h_cnt_q, h_cnt_d;
  logic [YW-1:0] v_cnt_q, v_cnt_d;
  logic [XW-1:0] pix_x_q;
  logic [YW-1:0] pix_y_q;
  logic          pix_active_q, pix_active_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic [2:0]    sync_q, sync_d;       // {vs, hs, de} at output polarity
  logic [2:0]    sync_dly;

  // NOTE: every output of this block gets a default first, so no path
  // through the if-tree leaves a signal unassigned and infers a latch.
  always_comb begin
    h_cnt_d = h_cnt_q + XW'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + YW'(1);
    end
    pix_active_d  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    line_start_d  = (h_cnt_q == '0);
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    sync_d = {sync_level((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_LAST), VS_POL),
              sync_level((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_LAST), HS_POL),
              pix_active_d};
  end

  // NOTE: state updates use <= so every flop samples pre-edge values and
  // the counter/output-register ordering cannot create a race.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_active_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      sync_q        <= SYNC_IDLE;
    end else if (ce) begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pix_x_q       <= h_cnt_q;
      pix_y_q       <= v_cnt_q;
      pix_active_q  <= pix_active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      sync_q        <= sync_d;
    end
  end

  dvi_sync_delay #(
    .DEPTH (PIPE_DLY),
    .W     (3),
    .INIT  (SYNC_IDLE)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .d     (sync_q),
    .q     (sync_dly)
  );

  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_active  = pix_active_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign vga_de      = sync_dly[0];
  assign vga_hs      = sync_dly[1];
  assign vga_vs      = sync_dly[2];

endmodule

// File: tb/tb_dvi_video_timing.sv
// Bench for dvi_video_timing: four instances (default mode and small modes with
// both polarities and delays) checked every cycle against an enabled-edge-count model.
module tb_dvi_video_timing;

  typedef struct packed {
    int x; int y; int act; int ls; int fs; int de; int hs; int vs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   k = 0;          // enabled edges since the last reset edge

  always #5 clk = ~clk;

  // default 800x600 mode
  logic [10:0] d_x; logic [9:0] d_y;
  logic d_act, d_ls, d_fs, d_de, d_hs, d_vs;
  dvi_video_timing u_def (
    .clk(clk), .rst_n(rst_n), .ce(ce), .pix_x(d_x), .pix_y(d_y), .pix_active(d_act),
    .line_start(d_ls), .frame_start(d_fs), .vga_de(d_de), .vga_hs(d_hs), .vga_vs(d_vs));

  // tiny mode, negative sync, no delay
  logic [2:0] s_x, s_y;
  logic s_act, s_ls, s_fs, s_de, s_hs, s_vs;
  dvi_video_timing #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_ACTIVE(2), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(0)) u_sm (
    .clk(clk), .rst_n(rst_n), .ce(ce), .pix_x(s_x), .pix_y(s_y), .pix_active(s_act),
    .line_start(s_ls), .frame_start(s_fs), .vga_de(s_de), .vga_hs(s_hs), .vga_vs(s_vs));

  // same tiny mode, 3-stage delay
  logic [2:0] t_x, t_y;
  logic t_act, t_ls, t_fs, t_de, t_hs, t_vs;
  dvi_video_timing #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_ACTIVE(2), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(3)) u_sm3 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .pix_x(t_x), .pix_y(t_y), .pix_active(t_act),
    .line_start(t_ls), .frame_start(t_fs), .vga_de(t_de), .vga_hs(t_hs), .vga_vs(t_vs));

  // medium mode, mixed polarity, 2-stage delay
  logic [4:0] m_x; logic [2:0] m_y;
  logic m_act, m_ls, m_fs, m_de, m_hs, m_vs;
  dvi_video_timing #(.H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b0), .PIPE_DLY(2)) u_md (
    .clk(clk), .rst_n(rst_n), .ce(ce), .pix_x(m_x), .pix_y(m_y), .pix_active(m_act),
    .line_start(m_ls), .frame_start(m_fs), .vga_de(m_de), .vga_hs(m_hs), .vga_vs(m_vs));

  // Raster position p (enabled pixel index since reset) maps to (p mod HT, p/HT mod VT);
  // pix_* show position k-1, vga_* show position k-1-dly, inactive before that.
  function automatic exp_t model(input int kk, input int ha, input int hf, input int hsw,
                                 input int hb, input int va, input int vf, input int vsw,
                                 input int vb, input int hp, input int vp, input int dly);
    exp_t e;
    int ht, vt, p, xx, yy;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    e = '0;
    if (kk > 0) begin
      p = kk - 1;
      e.x   = p % ht;
      e.y   = (p / ht) % vt;
      e.act = int'(e.x < ha && e.y < va);
      e.ls  = int'(e.x == 0);
      e.fs  = int'(e.x == 0 && e.y == 0);
    end
    e.de = 0;
    e.hs = 1 - hp;
    e.vs = 1 - vp;
    if (kk - 1 - dly >= 0) begin
      p  = kk - 1 - dly;
      xx = p % ht;
      yy = (p / ht) % vt;
      e.de = int'(xx < ha && yy < va);
      e.hs = (xx >= ha + hf && xx < ha + hf + hsw) ? hp : 1 - hp;
      e.vs = (yy >= va + vf && yy < va + vf + vsw) ? vp : 1 - vp;
    end
    return e;
  endfunction

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s at k=%0d: got %0d, expected %0d", tag, k, obs, exp_v);
    end
  endtask

  task automatic check_inst(input string nm, input int x, input int y, input int act,
                            input int ls, input int fs, input int de, input int hs,
                            input int vs, input exp_t e);
    check({nm, ".pix_x"}, x, e.x);
    check({nm, ".pix_y"}, y, e.y);
    check({nm, ".pix_active"}, act, e.act);
    check({nm, ".line_start"}, ls, e.ls);
    check({nm, ".frame_start"}, fs, e.fs);
    check({nm, ".vga_de"}, de, e.de);
    check({nm, ".vga_hs"}, hs, e.hs);
    check({nm, ".vga_vs"}, vs, e.vs);
  endtask

  task automatic check_all();
    check_inst("def", int'(d_x), int'(d_y), int'(d_act), int'(d_ls), int'(d_fs),
               int'(d_de), int'(d_hs), int'(d_vs),
               model(k, 800, 40, 128, 88, 600, 1, 4, 23, 1, 1, 0));
    check_inst("sm", int'(s_x), int'(s_y), int'(s_act), int'(s_ls), int'(s_fs),
               int'(s_de), int'(s_hs), int'(s_vs),
               model(k, 4, 1, 1, 1, 2, 1, 1, 1, 0, 0, 0));
    check_inst("sm3", int'(t_x), int'(t_y), int'(t_act), int'(t_ls), int'(t_fs),
               int'(t_de), int'(t_hs), int'(t_vs),
               model(k, 4, 1, 1, 1, 2, 1, 1, 1, 0, 0, 3));
    check_inst("md", int'(m_x), int'(m_y), int'(m_act), int'(m_ls), int'(m_fs),
               int'(m_de), int'(m_hs), int'(m_vs),
               model(k, 10, 2, 3, 2, 4, 1, 2, 1, 1, 0, 2));
  endtask

  task automatic step(input logic r, input logic c);
    @(negedge clk);
    rst_n = r;
    ce    = c;
    @(posedge clk);
    if (!r) k = 0;
    else if (c) k++;
    #1;
    check_all();
  endtask

  int hs_cnt, de_cnt;

  initial begin
    // reset held 5 cycles with ce wandering
    for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom_range(0, 1)));
    // free run: more than two full lines of the default mode
    hs_cnt = 0;
    de_cnt = 0;
    for (int i = 0; i < 2200; i++) begin
      step(1'b1, 1'b1);
      if (k > 1056 && k <= 2112) begin
        hs_cnt += int'(d_hs);
        de_cnt += int'(d_de);
      end
    end
    check("def.hs_cycles_per_line", hs_cnt, 128);
    check("def.de_cycles_per_line", de_cnt, 800);
    // one-cycle reset mid-line at default pix_x = 400, then restart
    step(1'b0, 1'b1);
    for (int i = 0; i < 401; i++) step(1'b1, 1'b1);
    check("def.x_before_pulse", int'(d_x), 400);
    step(1'b0, 1'b1);
    for (int i = 0; i < 60; i++) step(1'b1, 1'b1);
    // ce alternating 1/0
    for (int i = 0; i < 400; i++) step(1'b1, 1'(i % 2 == 0));
    // random ce with occasional reset pulses
    for (int i = 0; i < 1200; i++)
      step(1'($urandom_range(0, 149) != 0), 1'($urandom_range(0, 3) != 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
